// File: rtl/veerwolf_uart_pkg.sv
// Shared definitions for the UART line monitor.
//   PAR_*       : parity mode encoding for the PARITY parameter
//   rx_state_t  : receiver FSM states
//   rx_entry_t  : decoded-byte FIFO entry {data, perr, ferr}
//   par_bit()   : expected parity bit over a zero-extended data word
package veerwolf_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

    // Zero bits above DATA_BITS do not change the XOR, so the full byte is safe to use.
    function automatic logic par_bit(input logic [7:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/veerwolf_sync_fifo.sv
// Single-clock FIFO with a valid/ready read side.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : push request; accepted when not full or when a pop happens in the same cycle
//   wr_data   : entry to push
//   full      : no free slot
//   rd_data   : head entry (combinational, zero when reset)
//   rd_valid  : FIFO non-empty
//   rd_ready  : consumer takes the head when rd_valid & rd_ready
module veerwolf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_pop, wr_ok;

    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_valid = (wptr != rptr);
    assign rd_data  = mem[rptr[AW-1:0]];
    assign rd_pop   = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_ok    = wr_en & (~full | rd_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_ok) begin
                mem[wptr[AW-1:0]] <= wr_data;
                wptr              <= wptr + 1'b1;
            end
            if (rd_pop) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/veerwolf_uart_monitor.sv
// UART receive-line monitor: decodes a serial line into bytes with parity,
// framing and break detection, buffering results in a small FIFO.
//   clk, rst     : clock, asynchronous active-high reset
//   i_rx         : serial line, idle high, asynchronous to clk
//   o_data       : FIFO head byte, zero-extended above DATA_BITS
//   o_perr/ferr  : parity / framing error flags of the head entry
//   o_valid      : FIFO non-empty; i_ready pops the head
//   o_break      : one-cycle pulse when a break frame is seen
//   o_overflow   : sticky, a decoded byte was dropped; cleared by i_clr
//   o_busy       : receiver not idle
module veerwolf_uart_monitor
    import veerwolf_uart_pkg::*;
#(
    parameter int DIV        = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_perr,
    output logic       o_ferr,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_break,
    output logic       o_overflow,
    input  logic       i_clr,
    output logic       o_busy
);

    localparam int CNT_W = $clog2(DIV);
    // Start-bit countdown: the edge is seen one cycle after rx_s falls and the
    // state change costs another, so this lands the sample DIV/2 after the fall.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 2);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIV - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    // Synchroniser plus one history flop for edge detection.
    logic rx_meta, rx_s, rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic             stop_cnt;
    logic [7:0]       shreg;
    logic             par_rx;
    logic             ferr_acc;
    logic             push_vld;
    rx_entry_t        push_entry;
    logic [7:0]       rx_data;
    logic             perr_w;
    logic             tick;

    // Bits shift in from the top, so the word ends up left-aligned.
    assign rx_data = shreg >> (8 - DATA_BITS);
    assign perr_w  = (PARITY != PAR_NONE) && (par_rx != par_bit(rx_data, PARITY == PAR_ODD));
    assign tick    = (cnt == '0);
    assign o_busy  = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            par_rx     <= 1'b0;
            ferr_acc   <= 1'b0;
            o_break    <= 1'b0;
            push_vld   <= 1'b0;
            push_entry <= '0;
        end else begin
            o_break  <= 1'b0;
            push_vld <= 1'b0;
            if (!tick) cnt <= cnt - 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (!rx_s && rx_prev) begin
                        state <= S_START;
                        cnt   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= S_IDLE;      // glitch, not a real start bit
                        end else begin
                            state    <= S_DATA;
                            cnt      <= FULL_LOAD;
                            bit_cnt  <= '0;
                            shreg    <= '0;
                            par_rx   <= 1'b0;
                            ferr_acc <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        cnt     <= FULL_LOAD;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state    <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                            stop_cnt <= 1'b0;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        cnt    <= FULL_LOAD;
                        par_rx <= rx_s;
                        state  <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        cnt <= FULL_LOAD;
                        if (!stop_cnt && !rx_s && rx_data == '0 && !par_rx) begin
                            // Line held low through the whole frame: break, no entry.
                            o_break <= 1'b1;
                            state   <= S_WAIT_IDLE;
                        end else if (stop_cnt == LAST_STOP) begin
                            state           <= S_IDLE;
                            push_vld        <= 1'b1;
                            push_entry.data <= rx_data;
                            push_entry.perr <= perr_w;
                            push_entry.ferr <= ferr_acc | ~rx_s;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                            ferr_acc <= ferr_acc | ~rx_s;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    rx_entry_t head;
    logic      fifo_full;

    veerwolf_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push_vld),
        .wr_data  (push_entry),
        .full     (fifo_full),
        .rd_data  (head),
        .rd_valid (o_valid),
        .rd_ready (i_ready)
    );

    assign o_data = head.data;
    assign o_perr = head.perr;
    assign o_ferr = head.ferr;

    // Set has priority over clear so a drop in the clear cycle is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_overflow <= 1'b0;
        end else if (push_vld && fifo_full && !(o_valid && i_ready)) begin
            o_overflow <= 1'b1;
        end else if (i_clr) begin
            o_overflow <= 1'b0;
        end
    end

endmodule
